match_selector: RTL and testbench

- Consumes the stream of 12-bit hamming weights produced by the line counter, one per template candidate position.
- Tracks the minimum weight (best match) and its candidate index over a search window of NUM_CAND candidates.
- Reports the winner with a done pulse and a threshold-hit flag to the downstream result/host interface.
- Holds the result until the next search starts or the search is aborted.

---
 rtl/match_selector_if.sv | 29 ++
 rtl/match_selector.sv | 119 +++++++++++
 tb/tb_match_selector.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/match_selector_if.sv
// Handshake and result bundle between the line-count stream, the match
// selector and the downstream result/host side.
interface match_selector_if #(
  parameter int CNT_W = 12,
  parameter int IDX_W = 10
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] cnt_in;
  logic             cnt_valid;
  logic [CNT_W-1:0] thresh;
  logic             in_ready;
  logic             busy;
  logic [CNT_W-1:0] best_cnt;
  logic [IDX_W-1:0] best_idx;
  logic             hit;
  logic             done;
  logic             result_valid;

  modport master (
    output start, abort, cnt_in, cnt_valid, thresh,
    input  in_ready, busy, best_cnt, best_idx, hit, done, result_valid
  );

  modport slave (
    input  start, abort, cnt_in, cnt_valid, thresh,
    output in_ready, busy, best_cnt, best_idx, hit, done, result_valid
  );
endinterface

// File: rtl/match_selector.sv
// Minimum-weight search over NUM_CAND candidate line counts. Reports the
// smallest count, its index and whether it beats the latched threshold.
module match_selector #(
  parameter int CNT_W    = 12,
  parameter int IDX_W    = 10,
  parameter int NUM_CAND = 1024
) (
  input logic             clk,
  input logic             rst_n,
  match_selector_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic             hit_q, hit_d;
  logic             done_q, done_d;
  logic             result_valid_q, result_valid_d;
  logic [CNT_W-1:0] thresh_q, thresh_d;

  logic             accept;
  logic             better;
  logic [CNT_W-1:0] cand_cnt;
  logic [IDX_W-1:0] cand_idx;

  // Candidate best after folding in the current sample (first sample always wins, ties keep the earlier index).
  always_comb begin
    accept   = (state_q == SCAN) && bus.cnt_valid;
    better   = (cnt_q == '0) || (bus.cnt_in < best_cnt_q);
    cand_cnt = better ? bus.cnt_in : best_cnt_q;
    cand_idx = better ? cnt_q : best_idx_q;
  end

  // Next-state and result update; abort beats start, start beats normal progress.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    best_cnt_d     = best_cnt_q;
    best_idx_d     = best_idx_q;
    hit_d          = hit_q;
    done_d         = 1'b0;
    result_valid_d = result_valid_q;
    thresh_d       = thresh_q;

    if (bus.abort) begin
      result_valid_d = 1'b0;
      if (state_q != IDLE) begin
        state_d    = IDLE;
        cnt_d      = '0;
        best_cnt_d = '1;
        best_idx_d = '0;
        hit_d      = 1'b0;
      end
    end else if (bus.start) begin
      state_d        = SCAN;
      cnt_d          = '0;
      best_cnt_d     = '1;
      best_idx_d     = '0;
      hit_d          = 1'b0;
      result_valid_d = 1'b0;
      thresh_d       = bus.thresh;
    end else begin
      case (state_q)
        SCAN: begin
          if (accept) begin
            best_cnt_d = cand_cnt;
            best_idx_d = cand_idx;
            cnt_d      = cnt_q + IDX_W'(1);
            if (cnt_q == LAST_IDX) begin
              state_d        = DONE;
              done_d         = 1'b1;
              result_valid_d = 1'b1;
              hit_d          = (cand_cnt <= thresh_q);
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      best_cnt_q     <= '1;
      best_idx_q     <= '0;
      hit_q          <= 1'b0;
      done_q         <= 1'b0;
      result_valid_q <= 1'b0;
      thresh_q       <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      best_cnt_q     <= best_cnt_d;
      best_idx_q     <= best_idx_d;
      hit_q          <= hit_d;
      done_q         <= done_d;
      result_valid_q <= result_valid_d;
      thresh_q       <= thresh_d;
    end
  end

  assign bus.in_ready     = (state_q == SCAN);
  assign bus.busy         = (state_q == SCAN);
  assign bus.best_cnt     = best_cnt_q;
  assign bus.best_idx     = best_idx_q;
  assign bus.hit          = hit_q;
  assign bus.done         = done_q;
  assign bus.result_valid = result_valid_q;

endmodule

// File: tb/tb_match_selector.sv
// Directed bench for match_selector: a NUM_CAND=4 instance for the main
// scenarios and a NUM_CAND=1 instance for the single-candidate boundary.
module tb_match_selector;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  match_selector_if #(.CNT_W(12), .IDX_W(10)) bus4 ();
  match_selector_if #(.CNT_W(12), .IDX_W(10)) bus1 ();

  match_selector #(.CNT_W(12), .IDX_W(10), .NUM_CAND(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  match_selector #(.CNT_W(12), .IDX_W(10), .NUM_CAND(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic ab, input logic vld,
                               input logic [11:0] cnt);
    bus4.start     = st;
    bus4.abort     = ab;
    bus4.cnt_valid = vld;
    bus4.cnt_in    = cnt;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0);
    bus4.thresh    = 12'd0;
    bus1.start     = 1'b0;
    bus1.abort     = 1'b0;
    bus1.cnt_valid = 1'b0;
    bus1.cnt_in    = 12'd0;
    bus1.thresh    = 12'd0;
    tick();
    tick();

    checkOutput("rst_in_ready", 32'(bus4.in_ready), 32'd0);
    checkOutput("rst_busy", 32'(bus4.busy), 32'd0);
    checkOutput("rst_best_cnt", 32'(bus4.best_cnt), 32'hFFF);
    checkOutput("rst_best_idx", 32'(bus4.best_idx), 32'd0);
    checkOutput("rst_hit", 32'(bus4.hit), 32'd0);
    checkOutput("rst_done", 32'(bus4.done), 32'd0);
    checkOutput("rst_rv", 32'(bus4.result_valid), 32'd0);
    rst_n = 1'b1;

    // Scenario 1: 100,50,75,50 thresh 60
    bus4.thresh = 12'd60;
    applyStimulus(1'b1, 1'b0, 1'b0, 12'd0);
    tick();
    checkOutput("s1_ready_after_start", 32'(bus4.in_ready), 32'd1);
    checkOutput("s1_busy", 32'(bus4.busy), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 12'd100); tick();
    checkOutput("s1_ready1", 32'(bus4.in_ready), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 12'd50);  tick();
    checkOutput("s1_ready2", 32'(bus4.in_ready), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 12'd75);  tick();
    checkOutput("s1_ready3", 32'(bus4.in_ready), 32'd1);
    checkOutput("s1_no_early_done", 32'(bus4.done), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 12'd50);  tick();
    checkOutput("s1_done", 32'(bus4.done), 32'd1);
    checkOutput("s1_ready_drop", 32'(bus4.in_ready), 32'd0);
    checkOutput("s1_best_cnt", 32'(bus4.best_cnt), 32'd50);
    checkOutput("s1_best_idx", 32'(bus4.best_idx), 32'd1);
    checkOutput("s1_hit", 32'(bus4.hit), 32'd1);
    checkOutput("s1_rv", 32'(bus4.result_valid), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 12'd1);  tick();
    checkOutput("s1_done_pulse_end", 32'(bus4.done), 32'd0);
    checkOutput("s1_rv_hold", 32'(bus4.result_valid), 32'd1);
    checkOutput("s1_best_hold", 32'(bus4.best_cnt), 32'd50);

    // Scenario 2: same stream, thresh 40
    bus4.thresh = 12'd40;
    applyStimulus(1'b1, 1'b0, 1'b0, 12'd0); tick();
    checkOutput("s2_rv_cleared", 32'(bus4.result_valid), 32'd0);
    checkOutput("s2_best_cleared", 32'(bus4.best_cnt), 32'hFFF);
    applyStimulus(1'b0, 1'b0, 1'b1, 12'd100); tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 12'd50);  tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 12'd75);  tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 12'd50);  tick();
    checkOutput("s2_done", 32'(bus4.done), 32'd1);
    checkOutput("s2_best_cnt", 32'(bus4.best_cnt), 32'd50);
    checkOutput("s2_best_idx", 32'(bus4.best_idx), 32'd1);
    checkOutput("s2_hit", 32'(bus4.hit), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0); tick();

    // abort in IDLE clears result_valid
    applyStimulus(1'b0, 1'b1, 1'b0, 12'd0); tick();
    checkOutput("idle_abort_rv", 32'(bus4.result_valid), 32'd0);

    // start and abort together: abort wins
    applyStimulus(1'b1, 1'b1, 1'b0, 12'd0); tick();
    checkOutput("start_abort_ready", 32'(bus4.in_ready), 32'd0);

    // Scenario 3: cnt_valid toggling 1,0,1,1,0,1 with 9,x,3,7,x,3
    bus4.thresh = 12'd5;
    applyStimulus(1'b1, 1'b0, 1'b0, 12'd0);   tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 12'd9);   tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd1);   tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 12'd3);   tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 12'd7);   tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0);   tick();
    checkOutput("s3_still_scan", 32'(bus4.in_ready), 32'd1);
    checkOutput("s3_no_done", 32'(bus4.done), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 12'd3);   tick();
    checkOutput("s3_done", 32'(bus4.done), 32'd1);
    checkOutput("s3_best_cnt", 32'(bus4.best_cnt), 32'd3);
    checkOutput("s3_best_idx", 32'(bus4.best_idx), 32'd1);
    checkOutput("s3_hit", 32'(bus4.hit), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0);   tick();

    // Scenario 4: abort mid-search
    applyStimulus(1'b1, 1'b0, 1'b0, 12'd0);   tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 12'd20);  tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 12'd10);  tick();
    checkOutput("s4_mid_best", 32'(bus4.best_cnt), 32'd10);
    applyStimulus(1'b0, 1'b1, 1'b0, 12'd0);   tick();
    checkOutput("s4_ready", 32'(bus4.in_ready), 32'd0);
    checkOutput("s4_rv", 32'(bus4.result_valid), 32'd0);
    checkOutput("s4_best_cnt", 32'(bus4.best_cnt), 32'hFFF);
    checkOutput("s4_best_idx", 32'(bus4.best_idx), 32'd0);
    checkOutput("s4_done", 32'(bus4.done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 12'd1); tick();
      checkOutput("s4_ignored_done", 32'(bus4.done), 32'd0);
    end
    checkOutput("s4_ignored_best", 32'(bus4.best_cnt), 32'hFFF);

    // Scenario 5: restart mid-search, sample on the start edge discarded
    bus4.thresh = 12'd4000;
    applyStimulus(1'b1, 1'b0, 1'b0, 12'd0);    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 12'd5);    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 12'd6);    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 12'd2);    tick();
    checkOutput("s5_restart_best", 32'(bus4.best_cnt), 32'hFFF);
    applyStimulus(1'b0, 1'b0, 1'b1, 12'd4000); tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 12'd3999); tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 12'd4000); tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 12'd4000); tick();
    checkOutput("s5_done", 32'(bus4.done), 32'd1);
    checkOutput("s5_best_cnt", 32'(bus4.best_cnt), 32'd3999);
    checkOutput("s5_best_idx", 32'(bus4.best_idx), 32'd1);
    checkOutput("s5_hit", 32'(bus4.hit), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0);    tick();

    // Scenario 6: reset pulse mid-search
    applyStimulus(1'b1, 1'b0, 1'b0, 12'd0);    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 12'd10);   tick();
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 12'd8);    tick();
    rst_n = 1'b1;
    checkOutput("s6_ready", 32'(bus4.in_ready), 32'd0);
    checkOutput("s6_busy", 32'(bus4.busy), 32'd0);
    checkOutput("s6_best_cnt", 32'(bus4.best_cnt), 32'hFFF);
    checkOutput("s6_best_idx", 32'(bus4.best_idx), 32'd0);
    checkOutput("s6_rv", 32'(bus4.result_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 12'd2);    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 12'd2);    tick();
    checkOutput("s6_ignored_best", 32'(bus4.best_cnt), 32'hFFF);
    checkOutput("s6_ignored_ready", 32'(bus4.in_ready), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0);

    // Single-candidate instance: first accepted sample completes the search
    bus1.thresh = 12'd6;
    bus1.start  = 1'b1; tick();
    bus1.start  = 1'b0;
    checkOutput("n1_ready", 32'(bus1.in_ready), 32'd1);
    bus1.cnt_valid = 1'b1;
    bus1.cnt_in    = 12'd7;
    tick();
    bus1.cnt_valid = 1'b0;
    checkOutput("n1_done", 32'(bus1.done), 32'd1);
    checkOutput("n1_best_cnt", 32'(bus1.best_cnt), 32'd7);
    checkOutput("n1_best_idx", 32'(bus1.best_idx), 32'd0);
    checkOutput("n1_hit", 32'(bus1.hit), 32'd0);
    checkOutput("n1_ready_drop", 32'(bus1.in_ready), 32'd0);
    tick();
    checkOutput("n1_done_end", 32'(bus1.done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
